// File: rtl/scan_pkg.sv
// Shared constants and helpers for the channel scan sequencer.
// Imported by the sequencer top and its next-channel finder.
package scan_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

  // Index of the highest set bit; 0 for an empty mask.
  function automatic logic [SEL_W-1:0] hi_bit(
    input logic [NCH-1:0] m
  );
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_next_chan.sv
// Circular find-first-set strictly above cur, wrapping 7 -> 0.
// A lone set bit at cur returns cur itself, flagged as a wrap.
module scan_next_chan
  import scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             valid,
  output logic             wrapped
);

  logic [SEL_W-1:0] idx;
  logic             found;

  // Walk cur+1 .. cur+8 (mod 8); the eighth step lands back on cur.
  always_comb begin
    nxt   = cur;
    idx   = cur;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = cur + SEL_W'(i);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    valid   = |mask;
    wrapped = valid && (nxt <= cur);
  end

endmodule

// File: rtl/scan_sequencer.sv
// Round-robin select generator for a 3-to-8 decoder.
// Dwell per channel, optional blanking gap, free-run or one frame.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               single,
  input  logic [NCH-1:0]     chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_en,
  output logic               frame_done,
  output logic               busy
);

  localparam int BW =
    (BLANK_CYC > 1) ? $clog2(BLANK_CYC + 1) : 1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sel_en_q, sel_en_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q, busy_d;
  logic               single_q, single_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [BW-1:0]      blank_cnt_q, blank_cnt_d;

  logic [SEL_W-1:0]   nc_cur;
  logic [SEL_W-1:0]   nc_nxt;
  logic               nc_valid;
  logic               nc_wrapped;
  logic [DWELL_W-1:0] dwell_ld;
  logic               enter_last;

  // From IDLE, searching above 7 yields the lowest set bit.
  assign nc_cur = (state_q == ST_IDLE) ? SEL_W'(NCH - 1) : sel_q;

  scan_next_chan u_next (
    .mask    (chan_mask),
    .cur     (nc_cur),
    .nxt     (nc_nxt),
    .valid   (nc_valid),
    .wrapped (nc_wrapped)
  );

  // A zero dwell still gives one enabled cycle.
  assign dwell_ld =
    (dwell == '0) ? DWELL_W'(1) : dwell;

  // Entering a one-cycle dwell on the top channel must flag now.
  assign enter_last =
    (dwell_ld == DWELL_W'(1)) &&
    (nc_nxt == hi_bit(chan_mask));

  // Next-state and registered-output logic for the scan FSM.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    sel_en_d     = sel_en_q;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    single_d     = single_q;
    dwell_cnt_d  = dwell_cnt_q;
    blank_cnt_d  = blank_cnt_q;

    case (state_q)
      ST_IDLE: begin
        sel_en_d = 1'b0;
        busy_d   = 1'b0;
        if (start && !stop && nc_valid) begin
          state_d      = ST_ACTIVE;
          sel_d        = nc_nxt;
          sel_en_d     = 1'b1;
          busy_d       = 1'b1;
          single_d     = single;
          dwell_cnt_d  = dwell_ld;
          frame_done_d = enter_last;
        end
      end

      ST_ACTIVE: begin
        if (stop) begin
          state_d     = ST_IDLE;
          sel_en_d    = 1'b0;
          busy_d      = 1'b0;
          dwell_cnt_d = '0;
        end else if (dwell_cnt_q > DWELL_W'(1)) begin
          dwell_cnt_d  = dwell_cnt_q - DWELL_W'(1);
          frame_done_d =
            (dwell_cnt_q == DWELL_W'(2)) &&
            (sel_q == hi_bit(chan_mask));
        end else if (BLANK_CYC > 0) begin
          state_d     = ST_BLANK;
          sel_en_d    = 1'b0;
          dwell_cnt_d = '0;
          blank_cnt_d = BW'(BLANK_CYC);
        end else if (!nc_valid ||
                     (nc_wrapped && single_q)) begin
          state_d     = ST_IDLE;
          sel_en_d    = 1'b0;
          busy_d      = 1'b0;
          dwell_cnt_d = '0;
        end else begin
          sel_d        = nc_nxt;
          dwell_cnt_d  = dwell_ld;
          frame_done_d = enter_last;
        end
      end

      ST_BLANK: begin
        if (stop) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          blank_cnt_d = '0;
        end else if (blank_cnt_q > BW'(1)) begin
          blank_cnt_d = blank_cnt_q - BW'(1);
        end else if (!nc_valid ||
                     (nc_wrapped && single_q)) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          blank_cnt_d = '0;
        end else begin
          state_d      = ST_ACTIVE;
          sel_d        = nc_nxt;
          sel_en_d     = 1'b1;
          blank_cnt_d  = '0;
          dwell_cnt_d  = dwell_ld;
          frame_done_d = enter_last;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        sel_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      sel_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      single_q     <= 1'b0;
      dwell_cnt_q  <= '0;
      blank_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_en_q     <= sel_en_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      single_q     <= single_d;
      dwell_cnt_q  <= dwell_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
    end
  end

  assign sel        = sel_q;
  assign sel_en     = sel_en_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: one instance with a 2-cycle gap and
// one with no gap, both compared against precomputed scan traces.
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        single = 1'b0;
  logic [7:0]  chan_mask = 8'h00;
  logic [15:0] dwell = 16'd0;

  logic [2:0] sel_b, sel_z;
  logic       en_b, en_z, fd_b, fd_z, busy_b, busy_z;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(16), .BLANK_CYC(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .single(single), .chan_mask(chan_mask), .dwell(dwell),
    .sel(sel_b), .sel_en(en_b), .frame_done(fd_b),
    .busy(busy_b)
  );

  scan_sequencer #(.DWELL_W(16), .BLANK_CYC(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .single(single), .chan_mask(chan_mask), .dwell(dwell),
    .sel(sel_z), .sel_en(en_z), .frame_done(fd_z),
    .busy(busy_z)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic       en;
    logic       fd;
    logic       busy;
  } obs_t;

  obs_t       qb[$];
  obs_t       qz[$];
  logic [2:0] last_b = 3'd0;
  logic [2:0] last_z = 3'd0;
  int         n_chk = 0;
  int         n_fail = 0;

  function automatic int max1(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int popc(input logic [7:0] m);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) if (m[i]) c++;
    return c;
  endfunction

  task automatic push(input int blank, input obs_t e);
    if (blank == 2) qb.push_back(e);
    else qz.push_back(e);
  endtask

  // Ascending enabled channels, each dwell cycles on then blank off;
  // frame_done on the final dwell cycle of the top channel.
  task automatic add_frames(input int blank, input logic [7:0] m,
                            input int d, input int nframes);
    int   hi;
    int   dl;
    obs_t e;
    hi = 0;
    dl = max1(d);
    for (int i = 0; i < 8; i++) if (m[i]) hi = i;
    for (int f = 0; f < nframes; f++) begin
      for (int ch = 0; ch < 8; ch++) begin
        if (m[ch]) begin
          for (int k = 1; k <= dl; k++) begin
            e.sel = 3'(ch); e.en = 1'b1; e.busy = 1'b1;
            e.fd = (ch == hi) && (k == dl);
            push(blank, e);
          end
          for (int k = 0; k < blank; k++) begin
            e.sel = 3'(ch); e.en = 1'b0; e.busy = 1'b1;
            e.fd = 1'b0;
            push(blank, e);
          end
        end
      end
    end
  endtask

  task automatic check(input string tag);
    obs_t eb, ez, ab, az;
    if (qb.size() > 0) eb = qb.pop_front();
    else eb = '{sel: last_b, en: 1'b0, fd: 1'b0, busy: 1'b0};
    if (qz.size() > 0) ez = qz.pop_front();
    else ez = '{sel: last_z, en: 1'b0, fd: 1'b0, busy: 1'b0};
    last_b = eb.sel;
    last_z = ez.sel;
    ab = '{sel: sel_b, en: en_b, fd: fd_b, busy: busy_b};
    az = '{sel: sel_z, en: en_z, fd: fd_z, busy: busy_z};
    n_chk++;
    assert (ab === eb) else begin
      n_fail++;
      $error("FAIL %s gap2 {sel,en,fd,busy} got %b want %b",
             tag, ab, eb);
    end
    n_chk++;
    assert (az === ez) else begin
      n_fail++;
      $error("FAIL %s gap0 {sel,en,fd,busy} got %b want %b",
             tag, az, ez);
    end
  endtask

  // One clock: release pulses after the edge, check mid-cycle.
  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    check(tag);
  endtask

  // Start a scan with a fixed mask; free-run scans end with stop.
  task automatic run(input logic [7:0] m, input int d,
                     input bit s, input int ncyc_in);
    int nf;
    int ncyc;
    qb.delete();
    qz.delete();
    nf = s ? 1 : (ncyc_in / (popc(m) * max1(d)) + 2);
    add_frames(2, m, d, nf);
    add_frames(0, m, d, nf);
    ncyc = s ? (qb.size() + 2) : ncyc_in;
    chan_mask = m;
    dwell = 16'(d);
    single = s;
    start = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      cyc("scan");
      if (!s && i == 5) start = 1'b1;
    end
    if (!s) begin
      stop = 1'b1;
      qb.delete();
      qz.delete();
      cyc("stop");
    end
    repeat (2) cyc("idle_after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;

    // Reset held, then idle with no start.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_reset");
    #1 rst_n = 1'b1;
    repeat (20) cyc("reset_idle");

    // Basic single frame, then free-run alternation with zero dwell.
    run(8'h05, 3, 1'b1, 0);
    run(8'h82, 0, 1'b0, 12);

    // Stop on the fourth active cycle, then a fresh start.
    run(8'hFF, 10, 1'b0, 4);
    run(8'hFF, 10, 1'b0, 30);

    // Start with an empty mask is ignored.
    chan_mask = 8'h00;
    start = 1'b1;
    repeat (3) cyc("start_mask0");

    // Start and stop together: stop wins.
    chan_mask = 8'h0F;
    start = 1'b1;
    stop = 1'b1;
    repeat (3) cyc("start_stop");

    // Mask cleared during the gap: idle at the advance, no pulse.
    qb.delete();
    qz.delete();
    e = '{sel: 3'd4, en: 1'b1, fd: 1'b0, busy: 1'b1};
    qb.push_back(e); qz.push_back(e);
    e.fd = 1'b1;
    qb.push_back(e); qz.push_back(e);
    e.fd = 1'b0;
    qz.push_back(e); qz.push_back(e);
    e.en = 1'b0;
    qb.push_back(e); qb.push_back(e);
    chan_mask = 8'h10;
    dwell = 16'd2;
    single = 1'b0;
    start = 1'b1;
    cyc("mask_clr");
    cyc("mask_clr");
    cyc("mask_clr");
    chan_mask = 8'h00;
    repeat (4) cyc("mask_clr");

    // Randomized scans against the trace model.
    for (int r = 0; r < 12; r++) begin
      logic [7:0] m;
      int d;
      bit s;
      m = 8'($urandom_range(1, 255));
      d = $urandom_range(0, 4);
      s = 1'($urandom_range(0, 1));
      run(m, d, s, $urandom_range(10, 60));
    end

    // Asynchronous reset between edges of an active scan.
    qb.delete();
    qz.delete();
    chan_mask = 8'h3C;
    dwell = 16'd5;
    single = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    last_b = 3'd0;
    last_z = 3'd0;
    check("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cyc("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
